// File: rtl/lcisc_context_writeback_if.sv
// Bundle between the last execution stage, the storage write port and the retire
// notification of lcisc_context_writeback.
interface lcisc_context_writeback_if #(
    parameter int THREAD_WORDS = 8,
    parameter int DATA_WORDS   = 8,
    parameter int SHARED_WORDS = 4,
    parameter int ID_W         = 2,
    parameter int DADDR_W      = 4
);
    localparam int BASE_W = (ID_W > DADDR_W) ? ID_W : DADDR_W;

    logic                      in_valid;
    logic                      in_ready;
    logic                      in_active;
    logic [ID_W-1:0]           in_id;
    logic [DADDR_W-1:0]        in_daddr;
    logic [32*THREAD_WORDS-1:0] in_thread;
    logic [32*SHARED_WORDS-1:0] in_shared;
    logic [32*DATA_WORDS-1:0]  in_data;

    logic                      wr_en;
    logic [1:0]                wr_sel;
    logic [BASE_W-1:0]         wr_base;
    logic [7:0]                wr_idx;
    logic [31:0]               wr_data;
    logic                      wr_ready;

    logic                      done;
    logic [ID_W-1:0]           done_id;

    modport slave (
        input  in_valid, in_active, in_id, in_daddr, in_thread, in_shared, in_data, wr_ready,
        output in_ready, wr_en, wr_sel, wr_base, wr_idx, wr_data, done, done_id
    );

    modport master (
        output in_valid, in_active, in_id, in_daddr, in_thread, in_shared, in_data, wr_ready,
        input  in_ready, wr_en, wr_sel, wr_base, wr_idx, wr_data, done, done_id
    );
endinterface

// File: rtl/lcisc_context_writeback.sv
// Retirement writeback for the LCISC pipeline: captures one pass and streams its thread,
// data and (optionally) shared words to storage as one u32 beat per cycle.
module lcisc_context_writeback #(
    parameter int THREAD_WORDS = 8,
    parameter int DATA_WORDS   = 8,
    parameter int SHARED_WORDS = 4,
    parameter int ID_W         = 2,
    parameter int DADDR_W      = 4,
    parameter int SHARED_WB    = 1
) (
    input logic                      clk,
    input logic                      reset,
    lcisc_context_writeback_if.slave bus
);
    localparam int BASE_W = (ID_W > DADDR_W) ? ID_W : DADDR_W;
    localparam logic [7:0] THREAD_LAST = 8'(THREAD_WORDS - 1);
    localparam logic [7:0] DATA_LAST   = 8'(DATA_WORDS - 1);
    localparam logic [7:0] SHARED_LAST = 8'(SHARED_WORDS - 1);

    // The word index is an 8-bit counter and every phase must hold at least one word.
    if (THREAD_WORDS < 1 || THREAD_WORDS > 255) begin : g_bad_thread_words
        $error("THREAD_WORDS must lie in 1..255");
    end
    if (DATA_WORDS < 1 || DATA_WORDS > 255) begin : g_bad_data_words
        $error("DATA_WORDS must lie in 1..255");
    end
    if (SHARED_WORDS < 1 || SHARED_WORDS > 255) begin : g_bad_shared_words
        $error("SHARED_WORDS must lie in 1..255");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        THREAD = 3'd1,
        DATA   = 3'd2,
        SHARED = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [7:0]                 idx_q, idx_d;
    logic [ID_W-1:0]            id_q;
    logic [DADDR_W-1:0]         daddr_q;
    logic [32*THREAD_WORDS-1:0] thread_q;
    logic [32*DATA_WORDS-1:0]   data_q;
    logic [32*SHARED_WORDS-1:0] shared_q;

    logic                       capture;
    logic [31:0]                threadWord;
    logic [31:0]                dataWord;
    logic [31:0]                sharedWord;

    assign capture = (state_q == IDLE) && bus.in_valid && bus.in_active;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Pass fields are sampled only at accept; later input changes cannot reach storage.
    always_ff @(posedge clk) begin
        if (!reset && capture) begin
            id_q     <= bus.in_id;
            daddr_q  <= bus.in_daddr;
            thread_q <= bus.in_thread;
            data_q   <= bus.in_data;
            shared_q <= bus.in_shared;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = THREAD;
                    idx_d   = 8'd0;
                end
            end
            THREAD: begin
                if (bus.wr_ready) begin
                    if (idx_q == THREAD_LAST) begin
                        state_d = DATA;
                        idx_d   = 8'd0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            DATA: begin
                if (bus.wr_ready) begin
                    if (idx_q == DATA_LAST) begin
                        state_d = (SHARED_WB != 0) ? SHARED : DONE;
                        idx_d   = 8'd0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            SHARED: begin
                if (bus.wr_ready) begin
                    if (idx_q == SHARED_LAST) begin
                        state_d = DONE;
                        idx_d   = 8'd0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = 8'd0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = 8'd0;
            end
        endcase
    end

    // Word selection per register; idx never exceeds the phase's last word.
    always_comb begin
        threadWord = 32'd0;
        dataWord   = 32'd0;
        sharedWord = 32'd0;
        for (int i = 0; i < THREAD_WORDS; i++) begin
            if (idx_q == 8'(i)) threadWord = thread_q[32*i +: 32];
        end
        for (int i = 0; i < DATA_WORDS; i++) begin
            if (idx_q == 8'(i)) dataWord = data_q[32*i +: 32];
        end
        for (int i = 0; i < SHARED_WORDS; i++) begin
            if (idx_q == 8'(i)) sharedWord = shared_q[32*i +: 32];
        end
    end

    // Outputs decode from registered state only, so they hold while storage stalls.
    always_comb begin
        bus.in_ready = (state_q == IDLE);
        bus.wr_en    = 1'b0;
        bus.wr_sel   = 2'd0;
        bus.wr_base  = '0;
        bus.wr_idx   = 8'd0;
        bus.wr_data  = 32'd0;
        bus.done     = 1'b0;
        bus.done_id  = '0;
        case (state_q)
            THREAD: begin
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 2'd0;
                bus.wr_base = BASE_W'(id_q);
                bus.wr_idx  = idx_q;
                bus.wr_data = threadWord;
            end
            DATA: begin
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 2'd1;
                bus.wr_base = BASE_W'(daddr_q);
                bus.wr_idx  = idx_q;
                bus.wr_data = dataWord;
            end
            SHARED: begin
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 2'd2;
                bus.wr_idx  = idx_q;
                bus.wr_data = sharedWord;
            end
            DONE: begin
                bus.done    = 1'b1;
                bus.done_id = id_q;
            end
            default: begin
                bus.wr_en = 1'b0;
            end
        endcase
    end
endmodule
